// File: rtl/dma_chunk_ctrl.sv
// dma_chunk_ctrl: splits one copy command into chunks of at most CHUNK_BYTES and
// sequences Read_Master/Write_Master per chunk. Rev 1.0
`default_nettype none

module dma_chunk_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 32,
  parameter int CHUNK_BYTES = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_src_addr,
  input  logic [ADDR_WIDTH-1:0] i_dst_addr,
  input  logic [LEN_WIDTH-1:0]  i_total_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic                  o_rd_start,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic [LEN_WIDTH-1:0]  o_rd_len,
  input  logic                  i_rd_done,
  input  logic                  i_rd_err,
  output logic                  o_wr_start,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [LEN_WIDTH-1:0]  o_wr_len,
  input  logic                  i_wr_done,
  input  logic                  i_wr_err
);

  localparam logic [LEN_WIDTH-1:0] CHUNK = LEN_WIDTH'(CHUNK_BYTES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] src, dst;
  logic [LEN_WIDTH-1:0]  remaining, chunk;
  logic [LEN_WIDTH-1:0]  chunk_sel, remaining_after;
  logic                  rd_seen, wr_seen;
  logic                  rd_hit, wr_hit, any_err;

  // A done pulse in the current cycle counts as if it were already latched.
  assign rd_hit          = rd_seen | i_rd_done;
  assign wr_hit          = wr_seen | i_wr_done;
  assign any_err         = i_rd_err | i_wr_err;
  assign chunk_sel       = (remaining < CHUNK) ? remaining : CHUNK;
  assign remaining_after = remaining - chunk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = (remaining == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (any_err)              state_nxt = S_DRAIN;
        else if (rd_hit && wr_hit) state_nxt = S_NEXT;
      end
      S_NEXT:  state_nxt = (remaining_after == '0) ? S_DONE : S_LOAD;
      S_DRAIN: if (rd_hit && wr_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src        <= '0;
      dst        <= '0;
      remaining  <= '0;
      chunk      <= '0;
      rd_seen    <= 1'b0;
      wr_seen    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
      o_rd_start <= 1'b0;
      o_wr_start <= 1'b0;
      o_rd_addr  <= '0;
      o_wr_addr  <= '0;
      o_rd_len   <= '0;
      o_wr_len   <= '0;
    end else begin
      o_rd_start <= 1'b0;
      o_wr_start <= 1'b0;
      o_done     <= 1'b0;
      case (state)
        S_IDLE: begin
          o_busy <= i_start;
          if (i_start) begin
            src       <= i_src_addr;
            dst       <= i_dst_addr;
            remaining <= {i_total_len[LEN_WIDTH-1:2], 2'b00};
            o_error   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (remaining != '0) begin
            chunk     <= chunk_sel;
            o_rd_addr <= src;
            o_wr_addr <= dst;
            o_rd_len  <= chunk_sel;
            o_wr_len  <= chunk_sel;
          end
        end
        S_ISSUE: begin
          o_rd_start <= 1'b1;
          o_wr_start <= 1'b1;
          rd_seen    <= 1'b0;
          wr_seen    <= 1'b0;
        end
        S_WAIT, S_DRAIN: begin
          if (i_rd_done) rd_seen <= 1'b1;
          if (i_wr_done) wr_seen <= 1'b1;
          if (any_err)   o_error <= 1'b1;
        end
        S_NEXT: begin
          remaining <= remaining_after;
          src       <= src + ADDR_WIDTH'(chunk);
          dst       <= dst + ADDR_WIDTH'(chunk);
        end
        S_DONE:  o_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dma_chunk_ctrl.sv
// tb_dma_chunk_ctrl: directed self-checking bench for dma_chunk_ctrl.
`default_nettype none

module tb_dma_chunk_ctrl;

  logic        clk;
  logic        reset_n;
  logic        i_start;
  logic [31:0] i_src_addr, i_dst_addr, i_total_len;
  logic        o_busy, o_done, o_error;
  logic        o_rd_start, o_wr_start;
  logic [31:0] o_rd_addr, o_rd_len, o_wr_addr, o_wr_len;
  logic        i_rd_done, i_rd_err, i_wr_done, i_wr_err;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  dma_chunk_ctrl #(.ADDR_WIDTH(32), .LEN_WIDTH(32), .CHUNK_BYTES(256)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start),
    .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr), .i_total_len(i_total_len),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_rd_start(o_rd_start), .o_rd_addr(o_rd_addr), .o_rd_len(o_rd_len),
    .i_rd_done(i_rd_done), .i_rd_err(i_rd_err),
    .o_wr_start(o_wr_start), .o_wr_addr(o_wr_addr), .o_wr_len(o_wr_len),
    .i_wr_done(i_wr_done), .i_wr_err(i_wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_rd_start) rd_cnt++;
    if (o_wr_start) wr_cnt++;
    if (o_done)     done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len);
    i_src_addr  = src;
    i_dst_addr  = dst;
    i_total_len = len;
    i_start     = 1'b1;
    step();
    i_start     = 1'b0;
    check("busy_after_start", o_busy, 1);
  endtask

  task automatic wait_start(output int n);
    n = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (o_rd_start === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (o_done === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  // Start pulse must arrive `lat` cycles later with the expected chunk descriptor.
  task automatic expect_chunk(input int lat, input logic [31:0] src, input logic [31:0] dst,
                              input logic [31:0] len);
    int n;
    wait_start(n);
    check("start_latency", n, lat);
    check("wr_start_with_rd", o_wr_start, 1);
    check("rd_addr", o_rd_addr, src);
    check("wr_addr", o_wr_addr, dst);
    check("rd_len", o_rd_len, len);
    check("wr_len", o_wr_len, len);
  endtask

  task automatic dones(input int rd_dly, input int wr_dly, input bit rd_e, input bit wr_e);
    int m;
    m = (rd_dly > wr_dly) ? rd_dly : wr_dly;
    for (int c = 0; c <= m; c++) begin
      i_rd_done = (c == rd_dly);
      i_wr_done = (c == wr_dly);
      i_rd_err  = rd_e && (c == rd_dly);
      i_wr_err  = wr_e && (c == wr_dly);
      step();
      check("no_done_while_waiting", o_done, 0);
      check("no_start_while_waiting", o_rd_start, 0);
    end
    i_rd_done = 1'b0;
    i_wr_done = 1'b0;
    i_rd_err  = 1'b0;
    i_wr_err  = 1'b0;
  endtask

  int n;
  int rd_base, done_base;
  logic [31:0] lens1000 [4];

  initial begin
    lens1000 = '{32'd256, 32'd256, 32'd256, 32'd232};
    reset_n = 1'b0;
    i_start = 1'b0;
    i_src_addr = '0; i_dst_addr = '0; i_total_len = '0;
    i_rd_done = 1'b0; i_rd_err = 1'b0; i_wr_done = 1'b0; i_wr_err = 1'b0;
    step();
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_error", o_error, 0);
    check("rst_rd_start", o_rd_start, 0);
    check("rst_rd_addr", o_rd_addr, 0);
    check("rst_wr_len", o_wr_len, 0);
    step();
    reset_n = 1'b1;
    step();

    // Single chunk of 64 bytes
    rd_base = rd_cnt; done_base = done_cnt;
    issue(32'h1000_0000, 32'hC000_0000, 32'd64);
    expect_chunk(2, 32'h1000_0000, 32'hC000_0000, 32'd64);
    dones(2, 1, 1'b0, 1'b0);
    wait_done(n);
    check("single_done_latency", n, 2);
    check("single_busy_in_done", o_busy, 1);
    check("single_error", o_error, 0);
    check("single_starts", rd_cnt - rd_base, 1);
    step();
    check("single_busy_drop", o_busy, 0);
    check("single_done_pulse", o_done, 0);
    check("single_done_count", done_cnt - done_base, 1);

    // 1000 bytes -> 256,256,256,232 with differing done orderings
    rd_base = rd_cnt; done_base = done_cnt;
    issue(32'h1000_0000, 32'hC000_0000, 32'd1000);
    for (int i = 0; i < 4; i++) begin
      expect_chunk((i == 0) ? 2 : 3, 32'h1000_0000 + 32'(i * 256),
                   32'hC000_0000 + 32'(i * 256), lens1000[i]);
      if (i == 1)      dones(5, 0, 1'b0, 1'b0);
      else if (i == 2) dones(0, 0, 1'b0, 1'b0);
      else             dones(1, 3, 1'b0, 1'b0);
    end
    wait_done(n);
    check("multi_done_latency", n, 2);
    check("multi_starts", rd_cnt - rd_base, 4);
    check("multi_wr_starts", wr_cnt - rd_base, 4);
    step();
    check("multi_done_count", done_cnt - done_base, 1);

    // Zero and sub-word lengths produce no chunks
    rd_base = rd_cnt;
    issue(32'h0, 32'h0, 32'd0);
    wait_done(n);
    check("zero_done_latency", n, 2);
    check("zero_busy", o_busy, 1);
    step();
    issue(32'h0, 32'h0, 32'd3);
    wait_done(n);
    check("len3_done_latency", n, 2);
    check("zero_len3_starts", rd_cnt - rd_base, 0);
    step();

    // len=7 -> one chunk of 4
    rd_base = rd_cnt;
    issue(32'h0000_0040, 32'h0000_0080, 32'd7);
    expect_chunk(2, 32'h0000_0040, 32'h0000_0080, 32'd4);
    dones(0, 0, 1'b0, 1'b0);
    wait_done(n);
    check("len7_done_latency", n, 2);
    check("len7_starts", rd_cnt - rd_base, 1);
    step();

    // Write error on chunk 2 of 1024: drain, no chunk 3
    rd_base = rd_cnt; done_base = done_cnt;
    issue(32'h2000_0000, 32'h3000_0000, 32'd1024);
    expect_chunk(2, 32'h2000_0000, 32'h3000_0000, 32'd256);
    dones(0, 0, 1'b0, 1'b0);
    expect_chunk(3, 32'h2000_0100, 32'h3000_0100, 32'd256);
    dones(2, 0, 1'b0, 1'b1);
    check("err_set", o_error, 1);
    wait_done(n);
    check("err_done_latency", n, 1);
    check("err_starts", rd_cnt - rd_base, 2);
    step();
    check("err_sticky", o_error, 1);
    check("err_done_count", done_cnt - done_base, 1);
    for (int k = 0; k < 4; k++) step();
    check("err_no_late_start", rd_cnt - rd_base, 2);
    issue(32'h0, 32'h0, 32'd0);
    check("err_cleared_by_start", o_error, 0);
    wait_done(n);
    step();

    // Ignored start while busy, plus destination wrap
    rd_base = rd_cnt; done_base = done_cnt;
    issue(32'h4000_0000, 32'hFFFF_FF00, 32'd1024);
    for (int i = 0; i < 4; i++) begin
      expect_chunk((i == 0) ? 2 : 3, 32'h4000_0000 + 32'(i * 256),
                   32'hFFFF_FF00 + 32'(i * 256), 32'd256);
      if (i == 0) begin
        i_total_len = 32'd4;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
      end
      dones(1, 1, 1'b0, 1'b0);
    end
    wait_done(n);
    check("robust_done_latency", n, 2);
    check("robust_starts", rd_cnt - rd_base, 4);
    step();
    check("robust_done_count", done_cnt - done_base, 1);

    // Reset asserted in WAIT aborts without a done pulse
    done_base = done_cnt;
    issue(32'h5000_0000, 32'h6000_0000, 32'd512);
    expect_chunk(2, 32'h5000_0000, 32'h6000_0000, 32'd256);
    step();
    reset_n = 1'b0;
    #1;
    check("abort_busy", o_busy, 0);
    check("abort_rd_addr", o_rd_addr, 0);
    check("abort_wr_addr", o_wr_addr, 0);
    check("abort_rd_len", o_rd_len, 0);
    check("abort_wr_len", o_wr_len, 0);
    check("abort_error", o_error, 0);
    step();
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("abort_no_done", done_cnt - done_base, 0);
    check("abort_idle_busy", o_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dma_chunk_ctrl.md
Name: dma_chunk_ctrl

Overview:
Transfer sequencer that sits between the DMA register/command interface and the Read_Master / Write_Master pair. It takes one copy command (source, destination, byte length) and splits it into chunks of at most CHUNK_BYTES, which keeps each chunk within the capacity of the shared data FIFO. For each chunk it starts both masters together, waits for both to complete, then advances the addresses. It reports busy, done and error status to software.

Parameters:
ADDR_WIDTH, 32, width of source/destination addresses.
LEN_WIDTH, 32, width of the total byte length.
CHUNK_BYTES, 256, maximum bytes per chunk; power of two, >= 4, <= FIFO depth in bytes.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
i_start  in  1  command strobe; sampled only in IDLE.
i_src_addr  in  ADDR_WIDTH  source byte address.
i_dst_addr  in  ADDR_WIDTH  destination byte address.
i_total_len  in  LEN_WIDTH  transfer length in bytes.
o_busy  out  1  high from the cycle after i_start is accepted until the cycle o_done pulses (inclusive).
o_done  out  1  one-cycle completion pulse.
o_error  out  1  sticky error flag; cleared on the next accepted i_start.
o_rd_start  out  1  one-cycle start pulse to Read_Master.
o_rd_addr  out  ADDR_WIDTH  chunk source address.
o_rd_len  out  LEN_WIDTH  chunk length in bytes.
i_rd_done  in  1  Read_Master chunk-complete pulse.
i_rd_err  in  1  Read_Master RRESP error pulse.
o_wr_start  out  1  one-cycle start pulse to Write_Master.
o_wr_addr  out  ADDR_WIDTH  chunk destination address.
o_wr_len  out  LEN_WIDTH  chunk length in bytes.
i_wr_done  in  1  Write_Master write-done pulse.
i_wr_err  in  1  Write_Master BRESP error pulse.

Behaviour:
- Reset (asynchronous, active-low):
  - state is IDLE.
  - All outputs, address/length registers, remaining-length counter and latch bits are 0.
  - Reset asserted mid-transfer aborts immediately with no o_done pulse. Masters are reset by the same reset_n.
- States: IDLE, LOAD, ISSUE, WAIT, NEXT, DRAIN, DONE.
- IDLE:
  - On i_start, capture addresses and remaining = i_total_len & ~3 (low 2 bits truncated).
  - Clear o_error and go to LOAD.
  - i_start is ignored in every other state.
- LOAD:
  - If remaining == 0, go to DONE.
  - Otherwise chunk = min(remaining, CHUNK_BYTES); drive o_rd_addr/o_wr_addr/o_rd_len/o_wr_len from the registers; go to ISSUE.
- ISSUE:
  - o_rd_start and o_wr_start are both high for exactly this one cycle.
  - Clear the rd_seen/wr_seen latches; go to WAIT.
  - Timing: i_start sampled at edge T gives start pulses in the cycle following edge T+2.
- Address/length outputs are held stable from ISSUE until the chunk's completion is observed.
- WAIT:
  - i_rd_done sets rd_seen and i_wr_done sets wr_seen. Pulses may arrive in either order or in the same cycle, including the first cycle of WAIT.
  - When rd_seen and wr_seen are both set (the latched value or this cycle's pulse counts), go to NEXT.
  - i_rd_err or i_wr_err sets o_error and goes to DRAIN; the done latches are kept.
- NEXT:
  - remaining -= chunk; src += chunk; dst += chunk.
  - Arithmetic is modulo 2^ADDR_WIDTH (wrap permitted, no error).
  - If the new remaining == 0, go to DONE; else go to LOAD.
- DRAIN:
  - Issue no new chunk.
  - Wait until both rd_seen and wr_seen are set, then go to DONE. The remaining chunks are abandoned.
  - An error pulse arriving in the same cycle as a done pulse still latches that done.
- DONE:
  - o_done is high for one cycle; o_busy drops in the following cycle; go to IDLE.
  - A zero-length command produces o_done in the cycle after edge T+2, with no master start pulses.
- o_error remains high after DONE until the next accepted i_start.

Test Plan:
- Single chunk: src=0x1000_0000, dst=0xC000_0000, len=64 → one start pair with rd_len=wr_len=64; o_done once, after both dones; o_error=0.
- Multi-chunk: len=1000, CHUNK_BYTES=256 → chunk lengths 256,256,256,232; dst addresses 0xC000_0000, +0x100, +0x200, +0x300; exactly 4 start pairs, then 1 o_done.
- Done ordering: on one chunk i_wr_done precedes i_rd_done by 5 cycles, on another they arrive in the same cycle → no early advance; next start pair issues in both cases.
- Zero/odd length: len=0 → o_done with no starts; len=3 → same behaviour; len=7 → one chunk of 4.
- Error: i_wr_err on chunk 2 of len=1024 → o_error=1, no chunk-3 start, o_done after both dones; o_error clears on the next i_start.
- Robustness: i_start pulsed while busy → ignored, and chunk count stays at 4 for len=1024; reset_n low in WAIT → all outputs 0 immediately and no o_done.
